// File: rtl/beamformer_pkg.sv
// Shared types and constants for the 16-mic beamformer front end.
package beamformer_pkg;
    localparam int NUM_MICS = 16;
    localparam int SAMPLE_W = 16;
    localparam int CHAN_W   = 4;

    typedef enum logic {ST_IDLE, ST_STREAM} state_e;
    typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/i2s_sync_edge.sv
// N-stage synchronizer for one asynchronous input, with rising/falling edge pulses
// taken from the synchronized level. STAGES must be at least 2.
module i2s_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/i2s_mic_deserializer.sv
// Captures one stereo I2S frame per data line, then streams the 2*NUM_LINES samples
// out one channel per valid/ready transfer. `define I2S_OVERRUN_CNT_EN adds overrun_cnt.
module i2s_mic_deserializer #(
    parameter int NUM_LINES   = 8,
    parameter int SAMPLE_W    = 16,
    parameter int SYNC_STAGES = 2,
    localparam int NCH        = 2 * NUM_LINES,
    localparam int CH_W       = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_clk,
    input  logic                 lr_clk,
    input  logic [NUM_LINES-1:0] sd_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SAMPLE_W-1:0]  out_data,
    output logic [CH_W-1:0]      out_chan,
    output logic                 out_last,
    output logic                 overrun
`ifdef I2S_OVERRUN_CNT_EN
    ,
    output logic [7:0]           overrun_cnt
`endif
);
    import beamformer_pkg::*;

    localparam int SLOT_W = $clog2(SAMPLE_W + 2);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SAMPLE_W + 1);

    logic bclk_rise, lr_s;
    logic [SYNC_STAGES-1:0][NUM_LINES-1:0] sd_sync_q;
    logic [NUM_LINES-1:0] sd_s;

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic lr_prev_q, lr_prev_d, aligned_q, aligned_d;
    logic [NCH-1:0][SAMPLE_W-1:0] cap_q, cap_d, hold_q, hold_d;
    state_e state_q, state_d;
    logic [CH_W-1:0] chan_q, chan_d;
    logic overrun_q, overrun_d;
    logic frame_done, drop, accept, at_last;

    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_bclk (
        .clk(clk), .rst(rst), .d_i(bit_clk), .q_o(), .rise_o(bclk_rise), .fall_o()
    );
    i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_lr (
        .clk(clk), .rst(rst), .d_i(lr_clk), .q_o(lr_s), .rise_o(), .fall_o()
    );

    assign sd_s = sd_sync_q[SYNC_STAGES-1];

    // Slot 0 is the I2S delay bit; slot n (1..SAMPLE_W) lands at bit SAMPLE_W-n so a
    // short slot leaves its LSBs at the zero written when the slot started.
    always_comb begin
        slot_d     = slot_q;
        lr_prev_d  = lr_prev_q;
        aligned_d  = aligned_q;
        cap_d      = cap_q;
        frame_done = 1'b0;
        if (bclk_rise) begin
            lr_prev_d = lr_s;
            if (lr_s != lr_prev_q) begin
                slot_d = '0;
                for (int l = 0; l < NUM_LINES; l++) begin
                    if (lr_s) cap_d[2*l+1] = '0;
                    else      cap_d[2*l]   = '0;
                end
                if (lr_prev_q) begin
                    aligned_d  = 1'b1;
                    frame_done = aligned_q;
                end
            end else begin
                if (slot_q != SLOT_MAX) slot_d = slot_q + SLOT_W'(1);
                for (int l = 0; l < NUM_LINES; l++) begin
                    for (int b = 0; b < SAMPLE_W; b++) begin
                        if (slot_d == SLOT_W'(SAMPLE_W - b)) begin
                            if (lr_s) cap_d[2*l+1][b] = sd_s[l];
                            else      cap_d[2*l][b]   = sd_s[l];
                        end
                    end
                end
            end
        end
    end

    assign accept  = out_valid & out_ready;
    assign at_last = (chan_q == CH_W'(NCH - 1));

    // The hold buffer counts as free if its last channel leaves in this very cycle.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        hold_d    = hold_q;
        overrun_d = overrun_q;
        drop      = 1'b0;
        if (state_q == ST_STREAM && accept) begin
            if (at_last) begin
                state_d = ST_IDLE;
                chan_d  = '0;
            end else begin
                chan_d = chan_q + CH_W'(1);
            end
        end
        if (frame_done) begin
            if (state_d == ST_IDLE) begin
                hold_d  = cap_q;
                state_d = ST_STREAM;
                chan_d  = '0;
            end else begin
                drop      = 1'b1;
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sd_sync_q <= '0;
            slot_q    <= '0;
            lr_prev_q <= 1'b0;
            aligned_q <= 1'b0;
            cap_q     <= '0;
            hold_q    <= '0;
            state_q   <= ST_IDLE;
            chan_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            sd_sync_q <= {sd_sync_q[SYNC_STAGES-2:0], sd_in};
            slot_q    <= slot_d;
            lr_prev_q <= lr_prev_d;
            aligned_q <= aligned_d;
            cap_q     <= cap_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
            chan_q    <= chan_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid = (state_q == ST_STREAM);
    assign out_data  = hold_q[chan_q];
    assign out_chan  = chan_q;
    assign out_last  = out_valid & at_last;
    assign overrun   = overrun_q;

`ifdef I2S_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            ovr_cnt_q <= '0;
        else if (drop && ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
    assign overrun_cnt = ovr_cnt_q;
`endif
endmodule

// File: tb/tb_i2s_mic_deserializer.sv
// Self-checking bench: drives I2S frames with random words and checks the stream
// against expected samples derived from the slot/bit rules.
`timescale 1ns/1ps
module tb_i2s_mic_deserializer;
    localparam int NL = 8;
    localparam int SW = 16;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic rst, bit_clk, lr_clk, out_valid, out_ready, out_last, overrun;
    logic [NL-1:0] sd_in;
    logic [SW-1:0] out_data;
    logic [3:0]    out_chan;
`ifdef I2S_OVERRUN_CNT_EN
    logic [7:0]    overrun_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {logic [SW-1:0] d; logic [3:0] c; logic l;} xfer_t;
    xfer_t exp_q[$];
    logic [31:0] lw[NL];
    logic [31:0] rw[NL];

    i2s_mic_deserializer #(.NUM_LINES(NL), .SAMPLE_W(SW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .bit_clk(bit_clk), .lr_clk(lr_clk), .sd_in(sd_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_chan(out_chan), .out_last(out_last), .overrun(overrun)
`ifdef I2S_OVERRUN_CNT_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected sample: the slot's bits after the delay bit, MSB first, zero-filled if short.
    function automatic logic [SW-1:0] model(input logic [31:0] w, input int slen);
        logic [SW-1:0] e;
        e = '0;
        for (int k = 0; k < SW; k++) if (k < slen - 1) e[SW-1-k] = w[31-k];
        return e;
    endfunction

    task automatic i2s_bit(input logic lr, input logic [NL-1:0] d);
        bit_clk = 1'b0; lr_clk = lr; sd_in = d;
        repeat (4) @(negedge clk);
        bit_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_half(input logic lr, input int slen);
        logic [NL-1:0] d;
        for (int i = 0; i < slen; i++) begin
            for (int l = 0; l < NL; l++)
                d[l] = (i == 0) ? 1'($urandom) : (lr ? rw[l][32-i] : lw[l][32-i]);
            i2s_bit(lr, d);
        end
    endtask

    task automatic send_frame(input int slen, input bit push);
        xfer_t e;
        send_half(1'b0, slen);
        send_half(1'b1, slen);
        if (push) begin
            for (int l = 0; l < NL; l++) begin
                e.d = model(lw[l], slen); e.c = 4'(2*l);   e.l = 1'b0;        exp_q.push_back(e);
                e.d = model(rw[l], slen); e.c = 4'(2*l+1); e.l = (l == NL-1); exp_q.push_back(e);
            end
        end
    endtask

    task automatic rand_words();
        for (int l = 0; l < NL; l++) begin lw[l] = $urandom; rw[l] = $urandom; end
    endtask

    task automatic preamble();
        repeat (3) i2s_bit(1'b1, NL'($urandom));
    endtask

    task automatic trailer();
        repeat (4) i2s_bit(1'b0, NL'($urandom));
    endtask

    task automatic do_reset();
        rst = 1'b1; bit_clk = 1'b0; lr_clk = 1'b1; sd_in = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.delete();
    endtask

    // Ready is chosen at the negedge, so a transfer seen here completes at the next posedge.
    task automatic consume(input string name, input int n, input int pct, input int stall_chan, input int budget);
        int got = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        xfer_t e;
        while (got < n && cyc < budget) begin
            @(negedge clk); cyc++;
            if (stall_chan >= 0 && !stalled && out_valid && out_chan == 4'(stall_chan)) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    n_cmp++; if (out_chan !== exp_q[0].c) begin n_err++; $display("FAIL %s stall chan: got %0d want %0d", name, out_chan, exp_q[0].c); end
                    n_cmp++; if (out_data !== exp_q[0].d) begin n_err++; $display("FAIL %s stall data: got %h want %h", name, out_data, exp_q[0].d); end
                    @(negedge clk); cyc++;
                end
            end
            out_ready = ($urandom_range(99) < pct);
            if (out_valid && out_ready) begin
                got++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL %s extra transfer: got chan %0d want none", name, out_chan);
                end else begin
                    e = exp_q.pop_front();
                    if (out_chan !== e.c) begin n_err++; $display("FAIL %s chan: got %0d want %0d", name, out_chan, e.c); end
                    n_cmp++; if (out_data !== e.d) begin n_err++; $display("FAIL %s data ch%0d: got %h want %h", name, e.c, out_data, e.d); end
                    n_cmp++; if (out_last !== e.l) begin n_err++; $display("FAIL %s last ch%0d: got %b want %b", name, e.c, out_last, e.l); end
                end
            end
        end
        n_cmp++;
        if (got != n) begin n_err++; $display("FAIL %s timeout: got %0d transfers want %0d", name, got, n); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_clk = 1'b0; lr_clk = 1'b1; sd_in = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0)    begin n_err++; $display("FAIL reset data: got %h want 0", out_data); end
        n_cmp++; if (out_chan !== '0)    begin n_err++; $display("FAIL reset chan: got %0d want 0", out_chan); end
        n_cmp++; if (out_last !== 1'b0)  begin n_err++; $display("FAIL reset last: got %b want 0", out_last); end
        n_cmp++; if (overrun !== 1'b0)   begin n_err++; $display("FAIL reset overrun: got %b want 0", overrun); end
`ifdef I2S_OVERRUN_CNT_EN
        n_cmp++; if (overrun_cnt !== 8'd0) begin n_err++; $display("FAIL reset cnt: got %0d want 0", overrun_cnt); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        for (int l = 0; l < NL; l++) begin
            lw[l] = {16'h1000 + 16'(l), 16'h0};
            rw[l] = {16'h2000 + 16'(l), 16'h0};
        end
        fork
            begin preamble(); send_frame(32, 1'b1); trailer(); end
            consume("basic", 16, 100, -1, 3000);
        join
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic idle: got valid %b want 0", out_valid); end
        n_cmp++; if (overrun !== 1'b0)   begin n_err++; $display("FAIL basic overrun: got %b want 0", overrun); end
    endtask

    task automatic test_alignment();
        rst = 1'b1; out_ready = 1'b0; exp_q.delete();
        fork
            begin
                rand_words();
                send_half(1'b0, 32);
                for (int i = 0; i < 32; i++) begin
                    if (i == 10) rst = 1'b0;
                    i2s_bit(1'b1, NL'($urandom));
                end
                rand_words();
                send_frame(32, 1'b1);
                trailer();
            end
            consume("align", 16, 100, -1, 4000);
        join
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL align idle: got valid %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        rand_words();
        fork
            begin preamble(); send_frame(32, 1'b1); trailer(); end
            consume("bp", 16, 100, 5, 3000);
        join
    endtask

    task automatic test_overrun();
        do_reset();
        preamble();
        rand_words(); send_frame(32, 1'b1);
        rand_words(); send_frame(32, 1'b0);
        trailer();
        n_cmp++; if (overrun !== 1'b1)   begin n_err++; $display("FAIL ovr flag: got %b want 1", overrun); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovr held valid: got %b want 1", out_valid); end
        n_cmp++; if (out_chan !== 4'd0)  begin n_err++; $display("FAIL ovr held chan: got %0d want 0", out_chan); end
`ifdef I2S_OVERRUN_CNT_EN
        n_cmp++; if (overrun_cnt !== 8'd1) begin n_err++; $display("FAIL ovr cnt: got %0d want 1", overrun_cnt); end
`endif
        consume("ovr", 16, 100, -1, 200);
        n_cmp++; if (overrun !== 1'b1)   begin n_err++; $display("FAIL ovr sticky: got %b want 1", overrun); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovr drained: got valid %b want 0", out_valid); end
    endtask

    task automatic test_boundary();
        xfer_t e;
        do_reset();
        fork
            begin preamble(); rand_words(); send_frame(32, 1'b1); rand_words(); send_frame(32, 1'b1); end
            consume("bnd_pre", 15, 100, -1, 2000);
        join
        // Accept channel 15 exactly in the cycle the synchronized bit_clk rise completes frame 2.
        bit_clk = 1'b0; lr_clk = 1'b0; sd_in = NL'($urandom);
        repeat (4) @(negedge clk);
        bit_clk = 1'b1;
        repeat (SS) @(negedge clk);
        out_ready = 1'b1;
        e = exp_q.pop_front();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bnd valid: got %b want 1", out_valid); end
        n_cmp++; if (out_chan !== e.c)   begin n_err++; $display("FAIL bnd chan: got %0d want %0d", out_chan, e.c); end
        n_cmp++; if (out_data !== e.d)   begin n_err++; $display("FAIL bnd data: got %h want %h", out_data, e.d); end
        n_cmp++; if (out_last !== e.l)   begin n_err++; $display("FAIL bnd last: got %b want %b", out_last, e.l); end
        @(negedge clk);
        out_ready = 1'b0;
        repeat (4 - SS - 1) @(negedge clk);
        repeat (3) i2s_bit(1'b0, NL'($urandom));
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL bnd overrun: got %b want 0", overrun); end
        consume("bnd_next", 16, 100, -1, 200);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bnd idle: got valid %b want 0", out_valid); end
    endtask

    task automatic test_ext_reset();
        do_reset();
        rand_words();
        lw[0] = {24'hABCDEF, 8'($urandom)};
        fork
            begin preamble(); send_frame(32, 1'b1); trailer(); end
            consume("ext", 16, 100, -1, 3000);
        join
        rand_words();
        send_frame(32, 1'b0);
        trailer();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst pre valid: got %b want 1", out_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst valid: got %b want 0", out_valid); end
        n_cmp++; if (out_chan !== 4'd0)  begin n_err++; $display("FAIL midrst chan: got %0d want 0", out_chan); end
        n_cmp++; if (out_data !== '0)    begin n_err++; $display("FAIL midrst data: got %h want 0", out_data); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        int lens[4] = '{12, 17, 20, 32};
        do_reset();
        fork
            begin
                preamble();
                for (int f = 0; f < 6; f++) begin
                    rand_words();
                    send_frame(lens[$urandom_range(3)], 1'b1);
                end
                trailer();
            end
            consume("rand", 96, 60, -1, 20000);
        join
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rand overrun: got %b want 0", overrun); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alignment();
        test_backpressure();
        test_overrun();
        test_boundary();
        test_ext_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
